// File: rtl/tpu_axi_mem_slave.sv
// AXI4 INCR burst slave over a word-addressed SRAM.
// One transaction at a time; AR/AW contention alternates priority.
module tpu_axi_mem_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   output logic [1:0]              s_axi_bresp,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    busy
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int SZ    = $clog2(BYTES);
   localparam int AIW   = $clog2(DEPTH);
   localparam int XW    = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WDATA,
      S_WRESP,
      S_RDATA
   } state_t;

   state_t                  state;
   state_t                  state_nx;
   logic                    prio;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [7:0]              len;
   logic [8:0]              beat;
   logic                    err;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    ar_hs;
   logic                    aw_hs;
   logic                    w_hs;
   logic                    r_hs;
   logic                    ar_err;
   logic                    aw_err;

   logic [XW-1:0]           wr_idx;
   logic                    wr_in;
   logic                    wr_past;
   logic                    wr_en;

   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [8:0]              rd_beat;
   logic [7:0]              rd_len;
   logic                    rd_err;
   logic [XW-1:0]           rd_idx;
   logic                    rd_ok;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [1:0]              rd_resp;
   logic                    rd_last;

   // Full-width word index so out-of-range bursts never alias onto low memory.
   function automatic logic [XW-1:0] word_idx(
      input logic [ADDR_WIDTH-1:0] a,
      input logic [8:0]            b
   );
      return {1'b0, a >> SZ} + XW'(b);
   endfunction

   assign ar_err = (s_axi_arburst != 2'b01) || (s_axi_arsize != 3'(SZ));
   assign aw_err = (s_axi_awburst != 2'b01) || (s_axi_awsize != 3'(SZ));

   assign ar_hs = s_axi_arvalid && s_axi_arready;
   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;
   assign r_hs  = s_axi_rvalid && s_axi_rready;
   assign busy  = (state != S_IDLE);

   assign wr_idx  = word_idx(addr, beat);
   assign wr_in   = (wr_idx < XW'(DEPTH));
   assign wr_past = (beat > {1'b0, len});
   assign wr_en   = rst_n && w_hs && wr_in && !wr_past && !err;

   // Read source: the new AR in idle, otherwise the beat after the current one.
   always_comb begin
      rd_addr = addr;
      rd_beat = beat + 9'd1;
      rd_len  = len;
      rd_err  = err;
      if (state == S_IDLE) begin
         rd_addr = s_axi_araddr;
         rd_beat = 9'd0;
         rd_len  = s_axi_arlen;
         rd_err  = ar_err;
      end
   end

   assign rd_idx  = word_idx(rd_addr, rd_beat);
   assign rd_ok   = !rd_err && (rd_idx < XW'(DEPTH));
   assign rd_word = rd_ok ? mem[rd_idx[AIW-1:0]] : '0;
   assign rd_resp = rd_ok ? 2'b00 : 2'b10;
   assign rd_last = (rd_beat == {1'b0, rd_len});

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      s_axi_awready = 1'b0;
      s_axi_arready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      s_axi_bresp   = 2'b00;
      s_axi_rvalid  = 1'b0;
      unique case (state)
         S_IDLE: begin
            s_axi_arready = s_axi_arvalid && !(s_axi_awvalid && prio);
            s_axi_awready = s_axi_awvalid && !(s_axi_arvalid && !prio);
            if (s_axi_arready)      state_nx = S_RDATA;
            else if (s_axi_awready) state_nx = S_WDATA;
         end
         S_WDATA: begin
            s_axi_wready = 1'b1;
            if (s_axi_wvalid && s_axi_wlast) state_nx = S_WRESP;
         end
         S_WRESP: begin
            s_axi_bvalid = 1'b1;
            s_axi_bresp  = err ? 2'b10 : 2'b00;
            if (s_axi_bready) state_nx = S_IDLE;
         end
         S_RDATA: begin
            s_axi_rvalid = 1'b1;
            if (s_axi_rready && s_axi_rlast) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio        <= 1'b0;
         addr        <= '0;
         len         <= '0;
         beat        <= '0;
         err         <= 1'b0;
         s_axi_rdata <= '0;
         s_axi_rresp <= 2'b00;
         s_axi_rlast <= 1'b0;
      end else begin
         if (ar_hs) begin
            addr        <= s_axi_araddr;
            len         <= s_axi_arlen;
            beat        <= '0;
            err         <= ar_err;
            prio        <= ~prio;
            s_axi_rdata <= rd_word;
            s_axi_rresp <= rd_resp;
            s_axi_rlast <= rd_last;
         end else if (aw_hs) begin
            addr <= s_axi_awaddr;
            len  <= s_axi_awlen;
            beat <= '0;
            err  <= aw_err;
            prio <= ~prio;
         end
         if (w_hs) begin
            beat <= beat + 9'd1;
            if (!wr_in || wr_past ||
                (s_axi_wlast && beat != {1'b0, len}))
               err <= 1'b1;
         end
         if (r_hs) begin
            if (s_axi_rlast) begin
               s_axi_rdata <= '0;
               s_axi_rresp <= 2'b00;
               s_axi_rlast <= 1'b0;
            end else begin
               beat        <= beat + 9'd1;
               s_axi_rdata <= rd_word;
               s_axi_rresp <= rd_resp;
               s_axi_rlast <= rd_last;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < BYTES; i++) begin
            if (s_axi_wstrb[i])
               mem[wr_idx[AIW-1:0]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_tpu_axi_mem_slave.sv
// Directed bench for tpu_axi_mem_slave.
// Drives at negedge / posedge+1, samples away from the rising edge.
module tb_tpu_axi_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid, wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid, rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tpu_axi_mem_slave #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .DEPTH(1024)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_axi_awvalid(awvalid),
      .s_axi_awready(awready),
      .s_axi_awaddr(awaddr),
      .s_axi_awlen(awlen),
      .s_axi_awsize(awsize),
      .s_axi_awburst(awburst),
      .s_axi_wvalid(wvalid),
      .s_axi_wready(wready),
      .s_axi_wdata(wdata),
      .s_axi_wstrb(wstrb),
      .s_axi_wlast(wlast),
      .s_axi_bvalid(bvalid),
      .s_axi_bready(bready),
      .s_axi_bresp(bresp),
      .s_axi_arvalid(arvalid),
      .s_axi_arready(arready),
      .s_axi_araddr(araddr),
      .s_axi_arlen(arlen),
      .s_axi_arsize(arsize),
      .s_axi_arburst(arburst),
      .s_axi_rvalid(rvalid),
      .s_axi_rready(rready),
      .s_axi_rdata(rdata),
      .s_axi_rresp(rresp),
      .s_axi_rlast(rlast),
      .busy(busy)
   );

   task automatic send_aw(input logic [31:0] a, input logic [7:0] l,
                          input logic [1:0] bt);
      int n = 0;
      @(negedge clk);
      awaddr = a; awlen = l; awsize = 3'd2; awburst = bt; awvalid = 1'b1;
      #1;
      while (!awready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (awready !== 1'b1) begin
         errors++;
         $display("FAIL aw_handshake awready=%b want 1", awready);
      end
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [7:0] l);
      int n = 0;
      @(negedge clk);
      araddr = a; arlen = l; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
      #1;
      while (!arready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (arready !== 1'b1) begin
         errors++;
         $display("FAIL ar_handshake arready=%b want 1", arready);
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                         input logic l);
      int n = 0;
      @(negedge clk);
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      #1;
      while (!wready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (wready !== 1'b1) begin
         errors++;
         $display("FAIL w_handshake wready=%b want 1", wready);
      end
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic recv_b(output logic [1:0] r);
      int n = 0;
      @(negedge clk);
      bready = 1'b1;
      while (!bvalid && n < 20) begin
         @(negedge clk); n++;
      end
      checks++;
      if (bvalid !== 1'b1) begin
         errors++;
         $display("FAIL b_timeout bvalid=%b want 1", bvalid);
      end
      r = bresp;
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic recv_r(output logic [31:0] d, output logic [1:0] r,
                         output logic l);
      int n = 0;
      rready = 1'b1;
      @(negedge clk);
      while (!rvalid && n < 20) begin
         @(negedge clk); n++;
      end
      checks++;
      if (rvalid !== 1'b1) begin
         errors++;
         $display("FAIL r_timeout rvalid=%b want 1", rvalid);
      end
      d = rdata; r = rresp; l = rlast;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, awready, arready, wready, bvalid, rvalid, rlast} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b want 0000000",
                  {busy, awready, arready, wready, bvalid, rvalid, rlast});
      end
      checks++;
      if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
         errors++;
         $display("FAIL reset_data rdata=%h rresp=%b bresp=%b want 0",
                  rdata, rresp, bresp);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_burst();
      logic [31:0] d;
      logic [1:0]  r;
      logic        l;
      send_aw(32'h40, 8'd3, 2'b01);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy got=%b want 1", busy);
      end
      for (int i = 0; i < 4; i++)
         send_w(32'h11 * (i + 1), 4'hF, i == 3);
      recv_b(r);
      checks++;
      if (r !== 2'b00) begin
         errors++;
         $display("FAIL basic_bresp got=%b want 00", r);
      end
      send_ar(32'h40, 8'd3);
      checks++;
      if (rvalid !== 1'b1) begin
         errors++;
         $display("FAIL basic_latency rvalid=%b want 1", rvalid);
      end
      for (int i = 0; i < 4; i++) begin
         recv_r(d, r, l);
         checks++;
         if (d !== 32'h11 * (i + 1) || r !== 2'b00 || l !== (i == 3)) begin
            errors++;
            $display("FAIL basic_beat%0d got=%h/%b/%b want %h/00/%b",
                     i, d, r, l, 32'h11 * (i + 1), i == 3);
         end
      end
      checks++;
      if (rvalid !== 1'b0 || rlast !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_end rvalid=%b rlast=%b busy=%b want 0",
                  rvalid, rlast, busy);
      end
   endtask

   task automatic test_strobe();
      logic [31:0] d;
      logic [1:0]  r;
      logic        l;
      send_aw(32'h80, 8'd0, 2'b01);
      send_w(32'hAABBCCDD, 4'hF, 1'b1);
      recv_b(r);
      send_aw(32'h80, 8'd0, 2'b01);
      send_w(32'h11223344, 4'b0101, 1'b1);
      recv_b(r);
      checks++;
      if (r !== 2'b00) begin
         errors++;
         $display("FAIL strobe_bresp got=%b want 00", r);
      end
      send_ar(32'h80, 8'd0);
      recv_r(d, r, l);
      checks++;
      if (d !== 32'hAA22CC44 || r !== 2'b00 || l !== 1'b1) begin
         errors++;
         $display("FAIL strobe_data got=%h/%b/%b want aa22cc44/00/1", d, r, l);
      end
   endtask

   task automatic test_stall();
      logic [1:0]  r;
      logic [31:0] held;
      logic        stalled = 1'b0;
      int          nbeats = 0;
      int          cyc = 0;
      send_aw(32'h100, 8'd15, 2'b01);
      for (int i = 0; i < 16; i++)
         send_w(32'h1000 + i, 4'hF, i == 15);
      recv_b(r);
      send_ar(32'h100, 8'd15);
      held = 32'h0;
      while (nbeats < 16 && cyc < 200) begin
         rready = (cyc % 3 == 0);
         @(negedge clk);
         if (rvalid) begin
            if (stalled) begin
               checks++;
               if (rdata !== held) begin
                  errors++;
                  $display("FAIL stall_hold got=%h want %h", rdata, held);
               end
            end
            if (rready) begin
               checks++;
               if (rdata !== 32'h1000 + nbeats || rresp !== 2'b00 ||
                   rlast !== (nbeats == 15)) begin
                  errors++;
                  $display("FAIL stall_beat%0d got=%h/%b/%b want %h/00/%b",
                           nbeats, rdata, rresp, rlast, 32'h1000 + nbeats,
                           nbeats == 15);
               end
               nbeats++;
               stalled = 1'b0;
            end else begin
               held = rdata;
               stalled = 1'b1;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      rready = 1'b0;
      checks++;
      if (nbeats != 16) begin
         errors++;
         $display("FAIL stall_count got=%0d want 16", nbeats);
      end
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin
         errors++;
         $display("FAIL stall_extra rvalid=%b want 0", rvalid);
      end
   endtask

   task automatic test_range();
      logic [31:0] d;
      logic [1:0]  r;
      logic        l;
      logic [31:0] ed [4];
      logic [1:0]  er [4];
      ed[0] = 32'hDEAD0001; ed[1] = 32'hDEAD0002; ed[2] = 32'h0; ed[3] = 32'h0;
      er[0] = 2'b00; er[1] = 2'b00; er[2] = 2'b10; er[3] = 2'b10;
      send_aw(32'hFF8, 8'd1, 2'b01);
      send_w(32'hDEAD0001, 4'hF, 1'b0);
      send_w(32'hDEAD0002, 4'hF, 1'b1);
      recv_b(r);
      checks++;
      if (r !== 2'b00) begin
         errors++;
         $display("FAIL range_wbresp got=%b want 00", r);
      end
      send_ar(32'hFF8, 8'd3);
      for (int i = 0; i < 4; i++) begin
         recv_r(d, r, l);
         checks++;
         if (d !== ed[i] || r !== er[i] || l !== (i == 3)) begin
            errors++;
            $display("FAIL range_beat%0d got=%h/%b/%b want %h/%b/%b",
                     i, d, r, l, ed[i], er[i], i == 3);
         end
      end
   endtask

   task automatic test_contention();
      logic [1:0] r;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
      arvalid = 1'b1;
      awaddr = 32'h200; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
      awvalid = 1'b1;
      #1;
      checks++;
      if (arready !== 1'b1 || awready !== 1'b0) begin
         errors++;
         $display("FAIL prio_first arready=%b awready=%b want 1/0",
                  arready, awready);
      end
      @(posedge clk); #1;
      rready = 1'b1;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h11 || rlast !== 1'b1 ||
          awready !== 1'b0) begin
         errors++;
         $display("FAIL prio_read got=%b/%h/%b/%b want 1/00000011/1/0",
                  rvalid, rdata, rlast, awready);
      end
      @(posedge clk); #1;
      checks++;
      if (awready !== 1'b1 || arready !== 1'b0) begin
         errors++;
         $display("FAIL prio_second awready=%b arready=%b want 1/0",
                  awready, arready);
      end
      @(posedge clk); #1;
      awvalid = 1'b0; arvalid = 1'b0; rready = 1'b0;
      send_w(32'hA, 4'hF, 1'b0);
      send_w(32'hB, 4'hF, 1'b1);
      recv_b(r);
      checks++;
      if (r !== 2'b10) begin
         errors++;
         $display("FAIL early_wlast_bresp got=%b want 10", r);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      logic [1:0]  r;
      logic        l;
      send_aw(32'h40, 8'd3, 2'b10);
      for (int i = 0; i < 4; i++)
         send_w(32'h99 + i, 4'hF, i == 3);
      recv_b(r);
      checks++;
      if (r !== 2'b10) begin
         errors++;
         $display("FAIL wrap_bresp got=%b want 10", r);
      end
      send_ar(32'h40, 8'd3);
      for (int i = 0; i < 4; i++) begin
         recv_r(d, r, l);
         checks++;
         if (d !== 32'h11 * (i + 1) || r !== 2'b00) begin
            errors++;
            $display("FAIL wrap_mem%0d got=%h/%b want %h/00",
                     i, d, r, 32'h11 * (i + 1));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [1:0]  r;
      logic        l;
      send_ar(32'h100, 8'd15);
      recv_r(d, r, l);
      recv_r(d, r, l);
      checks++;
      if (d !== 32'h1001) begin
         errors++;
         $display("FAIL midrst_pre got=%h want 00001001", d);
      end
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (rvalid !== 1'b0 || busy !== 1'b0 || rlast !== 1'b0) begin
         errors++;
         $display("FAIL midrst_abort rvalid=%b busy=%b rlast=%b want 0",
                  rvalid, busy, rlast);
      end
      @(negedge clk); rst_n = 1'b1;
      rready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rvalid !== 1'b0 || bvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_after rvalid=%b bvalid=%b busy=%b want 0",
                  rvalid, bvalid, busy);
      end
      rready = 1'b0;
   endtask

   initial begin
      awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
      arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
      rready = 0;
      test_reset();
      test_basic_burst();
      test_strobe();
      test_stall();
      test_range();
      test_contention();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t limit=200000", $time);
      $fatal(1);
   end

endmodule
